// File: rtl/input_conditioner_pkg.sv
// Shared constants for the traffic-controller input front end: channel indices,
// default parameter values and the debounce counter width helper.
package input_conditioner_pkg;

  localparam int CH_SENSOR = 0;
  localparam int CH_WALK   = 1;
  localparam int CH_PROG   = 2;

  localparam int DEF_CHANNELS        = 3;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  // A bypassed filter (0 cycles) still gets a 1-bit counter so widths stay legal.
  function automatic int cnt_width(input int debounce_cycles);
    int w;
    w = $clog2(debounce_cycles + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/input_conditioner_sync_debounce_cell.sv
// One conditioner channel: metastability synchroniser, debounce counter,
// accepted level and registered rise/fall pulses.
module sync_debounce_cell
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  input  logic chan_en,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic rise_next
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (DEBOUNCE_CYCLES > 0) ? CNT_W'(DEBOUNCE_CYCLES - 1) : '0;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_s;

  // Shift chain always runs so the synchronised view stays current while disabled.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    sync_s = sync_q[SYNC_STAGES-1];
  end

  // Debounce: a differing value must persist DEBOUNCE_CYCLES cycles to be accepted.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (!chan_en) begin
      cnt_d   = '0;
      level_d = level_q;
    end else if (DEBOUNCE_CYCLES == 0) begin
      level_d = sync_s;
    end else if (sync_s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync_s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign rise_next  = rise_d;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: one sync/debounce cell per channel plus a
// registered any-rise summary aligned with the per-channel rise pulses.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int CHANNELS        = DEF_CHANNELS,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] async_in,
  input  logic [CHANNELS-1:0] chan_en,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_rise
);

  logic [CHANNELS-1:0] rise_next_s;
  logic                any_rise_q, any_rise_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    sync_debounce_cell #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .clk        (clk),
      .reset      (reset),
      .async_in   (async_in[i]),
      .chan_en    (chan_en[i]),
      .level_out  (level_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .rise_next  (rise_next_s[i])
    );
  end

  // Reduce the pre-register rise terms so any_rise lands in the same cycle as rise_pulse.
  always_comb begin
    any_rise_d = |rise_next_s;
  end

  // Summary register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      any_rise_q <= 1'b0;
    end else begin
      any_rise_q <= any_rise_d;
    end
  end

  assign any_rise = any_rise_q;

endmodule
